// File: rtl/shift_rx.sv
// Serial-to-parallel frame receiver: start bit, W data bits in either order, stop bit,
// word delivered on a valid/ready port with overrun and framing-error pulses.
module shift_rx #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_en,
    input  logic         dir,
    output logic [W-1:0] dout,
    output logic         dvalid,
    input  logic         dready,
    output logic         busy,
    output logic         ferr,
    output logic         ovr
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [W-1:0]   shreg;
    logic [W-1:0]   shreg_d;
    logic [W-1:0]   dout_d;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_d;
    logic           dir_q;
    logic           dir_d;
    logic           dvalid_d;
    logic           busy_d;
    logic           ferr_d;
    logic           ovr_d;
    logic           last_bit;
    logic           load_ok;

    assign last_bit = (cnt == CW'(W - 1));
    // A finished word may load if the slot is empty or is being emptied on this same edge.
    assign load_ok  = !dvalid || dready;

    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        cnt_d    = cnt;
        dir_d    = dir_q;
        dout_d   = dout;
        dvalid_d = dvalid && !dready;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        case (state)
            IDLE: begin
                if (sin_en && !sin) begin
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sin_en) begin
                    if (dir_q) begin
                        shreg_d = {shreg[W-2:0], sin};
                    end else begin
                        shreg_d = {sin, shreg[W-1:1]};
                    end
                    if (last_bit) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (sin_en) begin
                    state_d = IDLE;
                    if (sin) begin
                        if (load_ok) begin
                            dout_d   = shreg;
                            dvalid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            dout   <= '0;
            dvalid <= 1'b0;
            busy   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            state  <= state_d;
            shreg  <= shreg_d;
            cnt    <= cnt_d;
            dir_q  <= dir_d;
            dout   <= dout_d;
            dvalid <= dvalid_d;
            busy   <= busy_d;
            ferr   <= ferr_d;
            ovr    <= ovr_d;
        end
    end

endmodule

// File: tb/tb_shift_rx.sv
// Bench for shift_rx: directed frame scenarios plus randomized frames checked against
// a frame-level reference model that collects strobed bits into a queue.
module tb_shift_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b1;
    logic         sin_en = 1'b0;
    logic         dir = 1'b0;
    logic         dready = 1'b0;
    logic [W-1:0] dout;
    logic         dvalid;
    logic         busy;
    logic         ferr;
    logic         ovr;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit           m_bits[$];
    bit           m_dir = 1'b0;
    logic [W-1:0] m_dout = '0;
    logic         m_dvalid = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_ferr = 1'b0;
    logic         m_ovr = 1'b0;

    shift_rx #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .sin    (sin),
        .sin_en (sin_en),
        .dir    (dir),
        .dout   (dout),
        .dvalid (dvalid),
        .dready (dready),
        .busy   (busy),
        .ferr   (ferr),
        .ovr    (ovr)
    );

    always #5 clk = ~clk;

    // Word value of the collected frame: data bits follow the start bit in m_bits.
    function automatic logic [W-1:0] frame_word();
        int v = 0;
        for (int i = 0; i < W; i++) begin
            if (!m_dir) v = v + (int'(m_bits[1+i]) << i);
            else        v = (v << 1) | int'(m_bits[1+i]);
        end
        return v[W-1:0];
    endfunction

    task automatic model_step();
        bit nd;
        if (rst) begin
            m_bits.delete();
            m_dir = 1'b0; m_dout = '0; m_dvalid = 1'b0;
            m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            return;
        end
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        nd = m_dvalid && !dready;
        if (sin_en) begin
            if (m_bits.size() == 0) begin
                if (sin == 1'b0) begin
                    m_bits.push_back(1'b0);
                    m_dir = dir;
                end
            end else begin
                m_bits.push_back(sin);
                if (m_bits.size() == W + 2) begin
                    if (m_bits[W+1]) begin
                        if (!m_dvalid || dready) begin
                            m_dout = frame_word();
                            nd = 1'b1;
                        end else begin
                            m_ovr = 1'b1;
                        end
                    end else begin
                        m_ferr = 1'b1;
                    end
                    m_bits.delete();
                end
            end
        end
        m_dvalid = nd;
        m_busy = (m_bits.size() != 0);
    endtask

    // One clock: drive inputs, let the edge happen, update the model, sample 1 time unit later.
    task automatic cyc(input logic s, input logic e, input logic d, input logic r);
        sin = s; sin_en = e; dir = d; dready = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic dv, input logic stop,
                              input logic tog, input logic rd, input logic rd_stop,
                              input int maxgap);
        logic [W+1:0] seq;
        logic cur_dir;
        seq[0] = 1'b0;
        for (int i = 0; i < W; i++) seq[1+i] = dv ? word[W-1-i] : word[i];
        seq[W+1] = stop;
        cur_dir = dv;
        for (int i = 0; i < W + 2; i++) begin
            if (i > 0) repeat ($urandom_range(maxgap, 0)) cyc(1'($urandom), 1'b0, cur_dir, rd);
            cyc(seq[i], 1'b1, cur_dir, (i == W + 1) ? rd_stop : rd);
            if (tog) cur_dir = ~dv;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({dout, dvalid, busy, ferr, ovr} !== '0) begin
            errors++;
            $display("FAIL reset_values: got dout=%h dvalid=%b busy=%b ferr=%b ovr=%b, want all 0",
                     dout, dvalid, busy, ferr, ovr);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({dout, dvalid, busy, ferr, ovr} !== '0) begin
                errors++;
                $display("FAIL idle_strobes[%0d]: got dout=%h dvalid=%b busy=%b ferr=%b ovr=%b, want all 0",
                         i, dout, dvalid, busy, ferr, ovr);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [5:0] s;
        s = 6'b110100;
        for (int i = 0; i < 6; i++) begin
            cyc(s[i], 1'b1, 1'b0, 1'b1);
            checks++;
            if (busy !== (i < 5)) begin
                errors++;
                $display("FAIL lsb_busy[%0d]: got %b want %b", i, busy, (i < 5));
            end
        end
        checks++;
        if (dvalid !== 1'b1 || dout !== 4'hA) begin
            errors++;
            $display("FAIL lsb_word: got dvalid=%b dout=%h want 1/a", dvalid, dout);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dvalid !== 1'b0) begin
            errors++;
            $display("FAIL lsb_dvalid_one_cycle: got %b want 0", dvalid);
        end
    endtask

    task automatic test_msb_first();
        send_frame(4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (dvalid !== 1'b1 || dout !== 4'h5) begin
            errors++;
            $display("FAIL msb_word_dir_toggled: got dvalid=%b dout=%h want 1/5", dvalid, dout);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dvalid !== 1'b0) begin
            errors++;
            $display("FAIL msb_accept: got dvalid=%b want 0", dvalid);
        end
    endtask

    task automatic test_framing_error();
        send_frame(4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        checks++;
        if (ferr !== 1'b1 || dvalid !== 1'b0 || dout !== 4'h5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_pulse: got ferr=%b dvalid=%b dout=%h busy=%b want 1/0/5/0",
                     ferr, dvalid, dout, busy);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ferr !== 1'b0) begin
            errors++;
            $display("FAIL ferr_one_cycle: got %b want 0", ferr);
        end
        send_frame(4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        checks++;
        if (dvalid !== 1'b1 || dout !== 4'h1) begin
            errors++;
            $display("FAIL after_ferr_word: got dvalid=%b dout=%h want 1/1", dvalid, dout);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (dvalid !== 1'b1 || dout !== 4'h3) begin
            errors++;
            $display("FAIL ovr_first_word: got dvalid=%b dout=%h want 1/3", dvalid, dout);
        end
        send_frame(4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (ovr !== 1'b1 || dvalid !== 1'b1 || dout !== 4'h3) begin
            errors++;
            $display("FAIL ovr_pulse: got ovr=%b dvalid=%b dout=%h want 1/1/3", ovr, dvalid, dout);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ovr !== 1'b0 || dvalid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_one_cycle: got ovr=%b dvalid=%b want 0/1", ovr, dvalid);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        send_frame(4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        checks++;
        if (ovr !== 1'b0 || dvalid !== 1'b1 || dout !== 4'hC) begin
            errors++;
            $display("FAIL simultaneous_accept: got ovr=%b dvalid=%b dout=%h want 0/1/c", ovr, dvalid, dout);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        send_frame(4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        checks++;
        if (dvalid !== 1'b1 || dout !== 4'h9) begin
            errors++;
            $display("FAIL b2b_first: got dvalid=%b dout=%h want 1/9", dvalid, dout);
        end
        send_frame(4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        checks++;
        if (dvalid !== 1'b1 || dout !== 4'h2) begin
            errors++;
            $display("FAIL b2b_second: got dvalid=%b dout=%h want 1/2", dvalid, dout);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] s;
        send_frame(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
        s = 3'b010;
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(5, 0)) cyc(1'b1, 1'b0, 1'b0, 1'b0);
            cyc(s[i], 1'b1, 1'b0, 1'b0);
        end
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || dvalid !== 1'b0 || dout !== 4'h0) begin
            errors++;
            $display("FAIL mid_frame_reset: got busy=%b dvalid=%b dout=%h want 0/0/0", busy, dvalid, dout);
        end
        send_frame(4'h6, 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 5);
        checks++;
        if (dvalid !== 1'b1 || dout !== 4'h6) begin
            errors++;
            $display("FAIL after_reset_word: got dvalid=%b dout=%h want 1/6", dvalid, dout);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [W+1:0] seq;
        logic         dv;
        logic         cur_dir;
        logic [W-1:0] word;
        for (int f = 0; f < 40; f++) begin
            word = W'($urandom);
            dv = 1'($urandom);
            seq[0] = 1'b0;
            for (int i = 0; i < W; i++) seq[1+i] = dv ? word[W-1-i] : word[i];
            seq[W+1] = ($urandom_range(9, 0) != 0);
            cur_dir = dv;
            repeat ($urandom_range(2, 0)) begin
                cyc(1'b1, 1'($urandom), cur_dir, 1'($urandom));
                checks++;
                if ({dout, dvalid, busy, ferr, ovr} !== {m_dout, m_dvalid, m_busy, m_ferr, m_ovr}) begin
                    errors++;
                    $display("FAIL random_idle[%0d]: got dout=%h v=%b b=%b fe=%b ov=%b want %h %b %b %b %b",
                             f, dout, dvalid, busy, ferr, ovr, m_dout, m_dvalid, m_busy, m_ferr, m_ovr);
                end
            end
            for (int i = 0; i < W + 2; i++) begin
                repeat ($urandom_range(3, 0)) begin
                    cyc(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
                    checks++;
                    if ({dout, dvalid, busy, ferr, ovr} !== {m_dout, m_dvalid, m_busy, m_ferr, m_ovr}) begin
                        errors++;
                        $display("FAIL random_gap[%0d]: got dout=%h v=%b b=%b fe=%b ov=%b want %h %b %b %b %b",
                                 f, dout, dvalid, busy, ferr, ovr, m_dout, m_dvalid, m_busy, m_ferr, m_ovr);
                    end
                end
                rst = ($urandom_range(199, 0) == 0);
                cyc(seq[i], 1'b1, (i == 0) ? dv : 1'($urandom), 1'($urandom));
                rst = 1'b0;
                checks++;
                if ({dout, dvalid, busy, ferr, ovr} !== {m_dout, m_dvalid, m_busy, m_ferr, m_ovr}) begin
                    errors++;
                    $display("FAIL random_strobe[%0d.%0d]: got dout=%h v=%b b=%b fe=%b ov=%b want %h %b %b %b %b",
                             f, i, dout, dvalid, busy, ferr, ovr, m_dout, m_dvalid, m_busy, m_ferr, m_ovr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_framing_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_rx.md
# shift_rx

Serial-to-parallel frame receiver: the receiving end of the team's universal shift register when that register is used as a serializer. It samples a single-bit line on qualified bit strobes, detects a start bit, assembles W data bits in either shift direction, checks the stop bit, and presents the word on a valid/ready output port. Overrun and framing faults are flagged.

## Interface
Parameters:
- W, default 4: data bits per frame; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
- sin  input  1  serial line. Idle level is 1.
- sin_en  input  1  bit strobe. sin is sampled only on edges where sin_en=1.
- dir  input  1  bit order. 0 = LSB first (shift right, new bit enters dout[W-1]). 1 = MSB first (shift left, new bit enters bit 0). Sampled with the start bit and held for the whole frame.
- dout  output  W  received word. Stable while dvalid=1.
- dvalid  output  1  dout holds an unconsumed word.
- dready  input  1  consumer accepts the word; a transfer occurs on an edge where dvalid=1 and dready=1.
- busy  output  1  a frame is in progress (state is not IDLE).
- ferr  output  1  one-cycle pulse: bad stop bit.
- ovr  output  1  one-cycle pulse: a completed word was dropped.

## Operation
- Frame format: start bit (0), then W data bits, then stop bit (1). Each bit occupies exactly one sin_en strobe.
- State machine:
  - IDLE: on sin_en=1 and sin=0, latch dir into dir_q, clear the bit counter, go to DATA. sin=1 strobes are ignored.
  - DATA: on each sin_en=1, shift sin into shreg according to dir_q and increment cnt. When the strobe that carries bit W-1 is taken, go to STOP.
  - STOP: on sin_en=1:
    - If sin=1 (frame good): if dvalid=0 or dready=1 on this edge, load dout<=shreg and set dvalid=1; otherwise pulse ovr, discard shreg, and leave dout unchanged.
    - If sin=0: pulse ferr, discard shreg, leave dout and dvalid unchanged.
    - Either way, go to IDLE. A framing error never re-arms as a start bit on the same strobe.
- Output port: dvalid clears on a transfer edge, unless a new word loads on that same edge; in that case dvalid stays 1 and dout takes the new word. No overrun is flagged in that case.
- Widths: cnt is ceil(log2(W)) bits wide and saturates at W-1. The shift register shreg is W bits wide.
- dir changes in the middle of a frame have no effect. Strobes are not required on consecutive cycles; any gap length is legal.

## Timing
- Reset values: state=IDLE, shreg=0, cnt=0, dir_q=0, dout=0, dvalid=0, busy=0, ferr=0, ovr=0.
- A reset in the middle of a frame aborts it and also drops any word pending in dout. Reset wins over every simultaneous event.
- Latency: dvalid and dout update on the same edge that samples a good stop bit, so they are visible in the next cycle. The total is W+2 strobes from start bit to dvalid.
- busy rises on the edge after the start-bit strobe and falls on the edge after the stop-bit strobe.
- ferr and ovr are registered. Each is high for exactly the one cycle after the stop-bit edge.
- Throughput: one word per W+2 strobes. Back-to-back frames are allowed: a start bit is accepted on the first strobe after STOP.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset and idle: hold rst for 2 cycles, then drive sin=1 with strobes for 10 cycles -> all outputs stay 0; busy=0.
- LSB-first receive, W=4, dir=0, dready=1: strobe sin = 0,0,1,0,1,1 -> dout=4'hA, dvalid high for 1 cycle. busy is high from the cycle after the start strobe through the cycle of the stop strobe.
- MSB-first receive, dir=1: same six strobes -> dout=4'h5. Toggling dir after the start bit leaves the result at 4'h5.
- Framing error: strobe 0,1,1,1,1,0 -> ferr pulses for 1 cycle, dvalid stays 0, dout keeps its previous value. The next frame 0,1,0,0,0,1 is received with dout=4'h1.
- Overrun and simultaneous accept:
  - With dready=0, receive 4'h3 and then 4'hC -> ovr pulses after the second stop bit and dout stays 4'h3.
  - Repeat with dready=1 asserted only on the second stop-bit edge -> no ovr, dvalid stays 1, dout=4'hC.
- Reset in the middle of a frame, with sparse strobes (gaps of 0-5 cycles): assert rst after 2 data bits -> busy=0 and dvalid=0 in the next cycle. A following full frame for 4'h6 is received correctly.
